// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-cache access sequencer: one request per load/store, stalls while outstanding.
// Define DMEM_TIMEOUT_EN to add the BUSY watchdog (sticky timeout, request dropped).
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_valid_i,
    input  logic        mem_load_i,
    input  logic        mem_store_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        mem_advance_i,
    output logic        dmem_read_o,
    output logic        dmem_write_o,
    output logic [31:0] dmem_address_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_mbe_o,
    input  logic        dmem_resp_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] load_data_o,
    output logic [1:0]  load_addr_lo_o,
    output logic        mem_stall_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic        read_q, read_d, write_q, write_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
    logic [3:0]  mbe_q, mbe_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        is_mem, aligned, accept;
    logic [3:0]  mbe_calc;
    logic [1:0]  lo;
    logic        unused_funct3;

    // funct3[2] only selects sign/zero extension, which the WB decoder handles.
    assign unused_funct3 = mem_funct3_i[2];
    assign lo            = mem_addr_i[1:0];
    assign is_mem        = mem_valid_i & (mem_load_i | mem_store_i);

    always_comb begin
        aligned  = 1'b1;
        mbe_calc = 4'b0001 << lo;
        if (mem_funct3_i[1]) begin
            aligned  = (lo == 2'b00);
            mbe_calc = 4'b1111;
        end else if (mem_funct3_i[0]) begin
            aligned  = ~lo[0];
            mbe_calc = 4'b0011 << lo;
        end
    end

    assign accept     = (state_q == StIdle) & is_mem & aligned;
    assign misalign_o = (state_q == StIdle) & is_mem & ~aligned;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic            expire;

    assign expire    = (state_q == StBusy) & ~dmem_resp_i & (cnt_q == CntMax);
    assign timeout_o = timeout_q;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q | expire;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == StBusy) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    logic expire;
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        read_d      = read_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mbe_d       = mbe_q;
        addr_lo_d   = addr_lo_q;
        load_data_d = load_data_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StBusy;
                    read_d    = mem_load_i;
                    write_d   = ~mem_load_i;
                    addr_d    = {mem_addr_i[31:2], 2'b00};
                    wdata_d   = mem_wdata_i << {lo, 3'b000};
                    mbe_d     = mbe_calc;
                    addr_lo_d = lo;
                end
            end
            StBusy: begin
                if (dmem_resp_i) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (read_q) begin
                        load_data_d = dmem_rdata_i;
                    end
                    state_d = mem_advance_i ? StIdle : StDone;
                end else if (expire) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (mem_advance_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mbe_q       <= '0;
            addr_lo_q   <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mbe_q       <= mbe_d;
            addr_lo_q   <= addr_lo_d;
            load_data_q <= load_data_d;
        end
    end

    assign mem_stall_o    = accept | ((state_q == StBusy) & ~dmem_resp_i);
    assign dmem_read_o    = read_q;
    assign dmem_write_o   = write_q;
    assign dmem_address_o = addr_q;
    assign dmem_wdata_o   = wdata_q;
    assign dmem_mbe_o     = mbe_q;
    assign load_data_o    = load_data_q;
    assign load_addr_lo_o = addr_lo_q;

endmodule
